reg_file_mp: RTL and testbench
==============================

Name: reg_file_mp

Overview:
- Parametrised successor to the 8-bit, 8-entry register file.
- Provides one write port and two registered read ports that both operate every cycle; reads are no longer suppressed on write cycles.
- Adds a write-to-read bypass, a stall hold, and a per-register busy scoreboard for the issue stage.
- Sits between decode/issue and execute/writeback in the core pipeline.

Parameters:
DATA_W, 8, data width in bits.
ADDR_W, 3, register index width; depth is 2**ADDR_W.
ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes and is never busy; 0 = register 0 is ordinary storage.
BYPASS, 1, 1 = a same-cycle write forwards to a matching read; 0 = the read returns the old contents.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-low reset.
rw  in  1  write enable.
rd  in  ADDR_W  write index.
rd_data  in  DATA_W  write data.
rs  in  ADDR_W  read port A index.
rt  in  ADDR_W  read port B index.
stall  in  1  hold read outputs and busy outputs.
issue_en  in  1  mark issue_rd as pending.
issue_rd  in  ADDR_W  destination being issued.
rs_data  out  DATA_W  port A data, registered.
rt_data  out  DATA_W  port B data, registered.
rs_busy  out  1  port A register pending, registered.
rt_busy  out  1  port B register pending, registered.

Behaviour:
- Reset (reset=0, asynchronous):
  - all storage entries = 0
  - rs_data = rt_data = 0
  - rs_busy = rt_busy = 0
  - scoreboard = all 0
  - Takes effect immediately, mid-operation included.
  - The first edge after release is a normal cycle.
- Write:
  - On the edge with rw=1, file[rd] <= rd_data.
  - If ZERO_REG=1 and rd=0, the write is discarded.
  - Writes are independent of stall.
- Read, latency 1 cycle, both ports every edge while stall=0:
  - If ZERO_REG=1 and the index is 0: data = 0.
  - Else if BYPASS=1, rw=1 and rd equals the index (and the write is not discarded): data = rd_data.
  - Else: data = file[index] before this edge's write.
  - rs and rt are independent; rs=rt is legal and both ports return the same value.
- Stall:
  - While stall=1, rs_data, rt_data, rs_busy and rt_busy hold their values.
  - Storage writes and scoreboard updates continue.
  - After deassertion, the next edge samples current contents, so no write is lost.
- Scoreboard, one bit per register:
  - An edge with issue_en=1 sets busy[issue_rd].
  - An edge with rw=1 clears busy[rd].
  - Same register set and cleared on the same edge: set wins (a new producer replaces the old one).
  - If ZERO_REG=1, index 0 is never set.
  - Busy is never set by rw.
- Busy read, same timing and stall rule as data:
  - rs_busy <= busy[rs] & ~(rw & rd==rs), so a completing write clears it in the same cycle the data is bypassed.
  - An issue on the same edge is not visible until the next read.
  - If ZERO_REG=1, a read of index 0 gives busy = 0.
- Widths:
  - No arithmetic.
  - Indices are unsigned ADDR_W.
  - rd_data is stored unmodified.

Test Plan:
1. Reset and read-after-write:
   - Assert reset=0 mid-stream → outputs go to 0 with no clock edge.
   - Release, write r5=0xA7, then read rs=5 → rs_data=0xA7 one cycle later.
2. Register 0:
   - With ZERO_REG=1, write rd=0 data 0xFF, read rs=0 → 0x00; issue_rd=0 → rs_busy stays 0.
   - Repeat with ZERO_REG=0 → 0xFF is read back.
3. Bypass:
   - r3=0x11; same edge rw=1, rd=3, rd_data=0x22, rs=3, rt=3.
   - BYPASS=1 → rs_data=rt_data=0x22.
   - BYPASS=0 → both return 0x11, then 0x22 on the following read.
4. Stall:
   - rs_data=0x44, stall=1 for 3 cycles while writing r2=0x55 with rs=2 → rs_data stays 0x44.
   - Release stall → 0x55 next cycle.
5. Scoreboard:
   - Issue r4 → rs=4 shows rs_busy=1.
   - Write r4 with issue_en=1, issue_rd=4 on the same edge → busy stays set.
   - Plain write r4 → rs_busy=0 in the bypass cycle.
6. Parameters:
   - DATA_W=16, ADDR_W=5: write r31=0xBEEF and r30=0x1234, read rs=31, rt=30 → 0xBEEF / 0x1234.

Source files
------------

// File: rtl/reg_file_mp.sv
// Multi-ported register file: one write port, two registered read ports,
// optional write-to-read bypass, stall hold on the read outputs, and a
// per-register busy scoreboard for the issue stage.
module reg_file_mp #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 3,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rw,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] rd_data,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  input  logic              stall,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              rs_busy,
  output logic              rt_busy
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [Depth];
  logic [Depth-1:0]  busy_q, busy_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d, rt_data_q, rt_data_d;
  logic              rs_busy_q, rs_busy_d, rt_busy_q, rt_busy_d;
  logic              wr_en;
  logic              rs_zero, rt_zero, issue_ok;

  // Writes to a hardwired register 0 are dropped entirely.
  assign wr_en    = rw & ~(ZERO_REG && (rd == '0));
  assign rs_zero  = ZERO_REG && (rs == '0);
  assign rt_zero  = ZERO_REG && (rt == '0);
  assign issue_ok = issue_en & ~(ZERO_REG && (issue_rd == '0));

  // Storage array; writes proceed regardless of stall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[rd] <= rd_data;
    end
  end

  // Scoreboard next state: writeback clears, issue sets, set wins on a tie.
  always_comb begin
    busy_d = busy_q;
    if (rw) begin
      busy_d[rd] = 1'b0;
    end
    if (issue_ok) begin
      busy_d[issue_rd] = 1'b1;
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Read-port next values: zero register, then bypass, then stored contents.
  always_comb begin
    rs_data_d = mem_q[rs];
    rt_data_d = mem_q[rt];
    if (BYPASS && wr_en && (rd == rs)) begin
      rs_data_d = rd_data;
    end
    if (BYPASS && wr_en && (rd == rt)) begin
      rt_data_d = rd_data;
    end
    if (rs_zero) begin
      rs_data_d = '0;
    end
    if (rt_zero) begin
      rt_data_d = '0;
    end
    // A completing write clears busy in the same cycle its data is forwarded.
    rs_busy_d = busy_q[rs] & ~(rw & (rd == rs)) & ~rs_zero;
    rt_busy_d = busy_q[rt] & ~(rw & (rd == rt)) & ~rt_zero;
  end

  // Registered read outputs, held while stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rs_data_q <= '0;
      rt_data_q <= '0;
      rs_busy_q <= 1'b0;
      rt_busy_q <= 1'b0;
    end else if (!stall) begin
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      rs_busy_q <= rs_busy_d;
      rt_busy_q <= rt_busy_d;
    end
  end

  assign rs_data = rs_data_q;
  assign rt_data = rt_data_q;
  assign rs_busy = rs_busy_q;
  assign rt_busy = rt_busy_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: three instances cover the default build,
// the ZERO_REG=0/BYPASS=0 build, and a 16-bit x 32-entry build.
module tb_reg_file_mp;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus for the 8-bit instances.
  logic       rw = 0, stall = 0, issue_en = 0;
  logic [2:0] rd = 0, rs = 0, rt = 0, issue_rd = 0;
  logic [7:0] rd_data = 0;
  logic [7:0] a_rs_data, a_rt_data, b_rs_data, b_rt_data;
  logic       a_rs_busy, a_rt_busy, b_rs_busy, b_rt_busy;

  // Stimulus for the wide instance.
  logic        c_rw = 0, c_stall = 0, c_issue_en = 0;
  logic [4:0]  c_rd = 0, c_rs = 0, c_rt = 0, c_issue_rd = 0;
  logic [15:0] c_rd_data = 0;
  logic [15:0] c_rs_data, c_rt_data;
  logic        c_rs_busy, c_rt_busy;

  int checks = 0;
  int errors = 0;

  reg_file_mp #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_a (
    .clk(clk), .reset(reset), .rw(rw), .rd(rd), .rd_data(rd_data), .rs(rs), .rt(rt),
    .stall(stall), .issue_en(issue_en), .issue_rd(issue_rd),
    .rs_data(a_rs_data), .rt_data(a_rt_data), .rs_busy(a_rs_busy), .rt_busy(a_rt_busy)
  );

  reg_file_mp #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_b (
    .clk(clk), .reset(reset), .rw(rw), .rd(rd), .rd_data(rd_data), .rs(rs), .rt(rt),
    .stall(stall), .issue_en(issue_en), .issue_rd(issue_rd),
    .rs_data(b_rs_data), .rt_data(b_rt_data), .rs_busy(b_rs_busy), .rt_busy(b_rt_busy)
  );

  reg_file_mp #(.DATA_W(16), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_c (
    .clk(clk), .reset(reset), .rw(c_rw), .rd(c_rd), .rd_data(c_rd_data), .rs(c_rs),
    .rt(c_rt), .stall(c_stall), .issue_en(c_issue_en), .issue_rd(c_issue_rd),
    .rs_data(c_rs_data), .rt_data(c_rt_data), .rs_busy(c_rs_busy), .rt_busy(c_rt_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One active edge, then settle so outputs are sampled away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state.
    #3;
    check("reset_a_rs_data", 32'(a_rs_data), 32'h0);
    check("reset_a_rt_busy", 32'(a_rt_busy), 32'h0);
    check("reset_b_rt_data", 32'(b_rt_data), 32'h0);
    check("reset_c_rs_data", 32'(c_rs_data), 32'h0);
    tick();
    reset = 1'b1;

    // Read after write.
    rw = 1; rd = 5; rd_data = 8'hA7; tick();
    rw = 0; rs = 5; tick();
    check("raw_a", 32'(a_rs_data), 32'hA7);
    check("raw_b", 32'(b_rs_data), 32'hA7);

    // Asynchronous reset mid-stream, between edges.
    reset = 1'b0; #2;
    check("async_rst_a", 32'(a_rs_data), 32'h0);
    check("async_rst_b", 32'(b_rs_data), 32'h0);
    tick();
    reset = 1'b1;
    tick();
    check("rst_cleared_storage", 32'(a_rs_data), 32'h0);

    // Register 0 behaviour, with an issue to r0 on the same edge.
    rw = 1; rd = 0; rd_data = 8'hFF; rs = 0; issue_en = 1; issue_rd = 0; tick();
    check("r0_a_same", 32'(a_rs_data), 32'h0);
    check("r0_b_nobypass", 32'(b_rs_data), 32'h0);
    rw = 0; issue_en = 0; tick();
    check("r0_a_data", 32'(a_rs_data), 32'h0);
    check("r0_a_busy", 32'(a_rs_busy), 32'h0);
    check("r0_b_data", 32'(b_rs_data), 32'hFF);
    check("r0_b_busy", 32'(b_rs_busy), 32'h1);
    rw = 1; rd = 0; rd_data = 8'hFF; tick();
    check("r0_b_busy_clr", 32'(b_rs_busy), 32'h0);
    rw = 0; tick();

    // Bypass.
    rw = 1; rd = 3; rd_data = 8'h11; tick();
    rd_data = 8'h22; rs = 3; rt = 3; tick();
    check("byp_a_rs", 32'(a_rs_data), 32'h22);
    check("byp_a_rt", 32'(a_rt_data), 32'h22);
    check("byp_b_rs", 32'(b_rs_data), 32'h11);
    check("byp_b_rt", 32'(b_rt_data), 32'h11);
    rw = 0; tick();
    check("byp_b_next", 32'(b_rs_data), 32'h22);

    // Stall holds outputs while writes continue.
    rw = 1; rd = 1; rd_data = 8'h44; rs = 1; tick();
    rw = 0; tick();
    check("stall_pre", 32'(a_rs_data), 32'h44);
    stall = 1; rw = 1; rd = 2; rd_data = 8'h55; rs = 2;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_hold_a", 32'(a_rs_data), 32'h44);
      check("stall_hold_b", 32'(b_rs_data), 32'h44);
    end
    stall = 0; rw = 0; tick();
    check("stall_rel_a", 32'(a_rs_data), 32'h55);
    check("stall_rel_b", 32'(b_rs_data), 32'h55);

    // Scoreboard.
    issue_en = 1; issue_rd = 4; rs = 4; tick();
    check("sb_issue_lat", 32'(a_rs_busy), 32'h0);
    issue_en = 0; tick();
    check("sb_issue_a", 32'(a_rs_busy), 32'h1);
    check("sb_issue_b", 32'(b_rs_busy), 32'h1);
    rw = 1; rd = 4; rd_data = 8'h66; issue_en = 1; issue_rd = 4; tick();
    check("sb_tie_read", 32'(a_rs_busy), 32'h0);
    rw = 0; issue_en = 0; tick();
    check("sb_set_wins", 32'(a_rs_busy), 32'h1);
    rw = 1; rd = 4; rd_data = 8'h77; tick();
    check("sb_wb_busy", 32'(a_rs_busy), 32'h0);
    check("sb_wb_data_a", 32'(a_rs_data), 32'h77);
    check("sb_wb_data_b", 32'(b_rs_data), 32'h66);
    rw = 0; tick();
    check("sb_after_busy", 32'(a_rs_busy), 32'h0);
    check("sb_after_data_b", 32'(b_rs_data), 32'h77);

    // Wide instance.
    c_rw = 1; c_rd = 31; c_rd_data = 16'hBEEF; tick();
    c_rd = 30; c_rd_data = 16'h1234; tick();
    c_rw = 0; c_rs = 31; c_rt = 30; tick();
    check("wide_rs", 32'(c_rs_data), 32'hBEEF);
    check("wide_rt", 32'(c_rt_data), 32'h1234);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
